// File: rtl/ic_lshr_uge_skolem_seq.sv
// Sequential Skolem-witness solver for (x >>u s) >=u t (MODE 0) or (s >>u x) >=u t (MODE 1).
// A bit-serial MSB-first comparison of the reference value v against t decides invertibility.
module ic_lshr_uge_skolem_seq #(
   parameter int W    = 4,
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] x,
   output logic         sat,
   output logic         busy
);

   localparam int IW = $clog2(W);
   localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CMP, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  s_lat, t_lat, v;
   logic [IW-1:0] idx;
   logic          gt, lt;
   logic          accept;

   // Largest value reachable by the shift expression over all x; v >=u t decides sat.
   function automatic logic [W-1:0] ref_value(input logic [W-1:0] sv);
      if (MODE == 0) begin
         ref_value = (sv >= W'(W)) ? '0 : ({W{1'b1}} >> sv);
      end else begin
         ref_value = sv;
      end
   endfunction

   // MODE 0: x = all-ones maximises x >> s; MODE 1: x = 0 leaves s unshifted.
   function automatic logic [W-1:0] witness(input logic ok);
      witness = (ok && (MODE == 0)) ? '1 : '0;
   endfunction

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD;
         LOAD:    state_nxt = CMP;
         CMP:     if (idx == '0) state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_lat     <= '0;
         t_lat     <= '0;
         v         <= '0;
         idx       <= IDX_TOP;
         gt        <= 1'b0;
         lt        <= 1'b0;
         x         <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  s_lat <= s;
                  t_lat <= t;
               end
            end
            LOAD: begin
               v   <= ref_value(s_lat);
               idx <= IDX_TOP;
               gt  <= 1'b0;
               lt  <= 1'b0;
            end
            CMP: begin
               // First differing bit from the MSB settles the ordering; later bits are ignored.
               if (!gt && !lt) begin
                  if (v[idx] && !t_lat[idx]) gt <= 1'b1;
                  if (!v[idx] && t_lat[idx]) lt <= 1'b1;
               end
               idx <= idx - IW'(1);
            end
            DONE: begin
               // First DONE cycle registers the verdict; it is then held until consumed.
               if (!out_valid) begin
                  sat       <= ~lt;
                  x         <= witness(~lt);
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  idx       <= IDX_TOP;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
